// File: rtl/io_ctrl_pkg.sv
// Shared constants and helpers for the architectural I/O controller.
// Byte width, pointer sizing and the reset level used by its blocks.
package io_ctrl_pkg;

  localparam int BYTE_W = 8;

  localparam logic RST_ACTIVE = 1'b0;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular FIFO with one extra pointer bit to tell full from empty.
// Head is combinational; there is no write-to-read bypass.
module byte_fifo
  import io_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = BYTE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head,
  output logic                      full,
  output logic                      empty,
  output logic [ptr_w(DEPTH)-1:0]   level
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] ONE = PW'(1);

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign full  = (wptr[PW-1] != rptr[PW-1]) &&
                 (wptr[PW-2:0] == rptr[PW-2:0]);
  assign empty = (wptr == rptr);
  assign level = wptr - rptr;
  assign head  = mem[rptr[PW-2:0]];
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;

  // Pointer update; both wrap modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + ONE;
      if (rd_en) rptr <= rptr + ONE;
    end
  end

  // Storage write; contents are left alone by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[PW-2:0]] <= push_data;
  end

endmodule

// File: rtl/arch_io_controller.sv
// Byte-stream bridge between CPU arch I/O ports and the host.
// Two FIFOs plus stall/gating; outputs forced quiet in reset.
module arch_io_controller
  import io_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_in_valid,
  input  logic [BYTE_W-1:0]        host_in_data,
  output logic                     host_in_ready,
  input  logic                     cpu_in_enable,
  output logic [BYTE_W-1:0]        cpu_in_value,
  input  logic                     cpu_out_enable,
  input  logic [BYTE_W-1:0]        cpu_out_value,
  output logic                     cpu_stall,
  output logic                     host_out_valid,
  output logic [BYTE_W-1:0]        host_out_data,
  input  logic                     host_out_ready,
  output logic [$clog2(DEPTH):0]   in_level
);

  localparam int PW = ptr_w(DEPTH);

  logic              run;
  logic              in_full;
  logic              in_empty;
  logic              out_full;
  logic              out_empty;
  logic [BYTE_W-1:0] in_head;
  logic [BYTE_W-1:0] out_head;
  logic [PW-1:0]     in_lvl;
  logic [PW-1:0]     out_lvl;
  logic              out_lvl_unused;
  logic              stall_raw;
  logic              in_push;
  logic              in_pop;
  logic              out_push;
  logic              out_pop;

  assign run = (rst != RST_ACTIVE);
  assign out_lvl_unused = ^out_lvl;

  // Stall, gating and reset forcing of the CPU/host handshakes.
  always_comb begin
    stall_raw = (cpu_in_enable & in_empty) |
                (cpu_out_enable & out_full);
    host_in_ready  = run & ~in_full;
    host_out_valid = run & ~out_empty;
    cpu_stall      = run & stall_raw;
    in_push  = host_in_valid & host_in_ready;
    in_pop   = run & cpu_in_enable & ~stall_raw;
    out_push = run & cpu_out_enable & ~stall_raw;
    out_pop  = host_out_valid & host_out_ready;
    cpu_in_value = '0;
    if (run && cpu_in_enable && !in_empty)
      cpu_in_value = in_head;
    host_out_data = host_out_valid ? out_head : '0;
    in_level      = run ? in_lvl : '0;
  end

  byte_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_in_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_push),
    .push_data (host_in_data),
    .pop       (in_pop),
    .head      (in_head),
    .full      (in_full),
    .empty     (in_empty),
    .level     (in_lvl)
  );

  byte_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (out_push),
    .push_data (cpu_out_value),
    .pop       (out_pop),
    .head      (out_head),
    .full      (out_full),
    .empty     (out_empty),
    .level     (out_lvl)
  );

endmodule
